// File: rtl/fetch_unit_if.sv
// Instruction-memory read port shared by the fetch unit and the memory model.
// The fetch side drives address/request; the memory side answers with
// a single-cycle ack carrying the read data.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues instruction-memory reads on
// request from the controller, latches the returned word into IR and
// computes the next PC (sequential, branch, jump, register jump).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_wr,
    input  logic                 ir_wr,
    input  logic [1:0]           npc_sel,
    input  logic [31:0]          rs_data,
    fetch_unit_if.master         imem,
    output logic [31:0]          ir,
    output logic [5:0]           opcode,
    output logic [5:0]           funct,
    output logic [4:0]           rs,
    output logic [4:0]           rt,
    output logic [4:0]           rd,
    output logic [15:0]          imm16,
    output logic [31:0]          pc,
    output logic [31:0]          pc_link,
    output logic                 ir_valid,
    output logic                 stall,
    output logic                 addr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] pc_ir_q, pc_ir_d;
    logic [31:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] pc_link_w;
    logic [31:0] branch_off;
    logic [31:0] npc;
    logic        in_fetch;

    assign in_fetch   = (state_q == FETCH);
    // Link value is tied to the address the current IR came from, not the live PC.
    assign pc_link_w  = pc_ir_q + 32'd4;
    assign branch_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    // Next-PC candidate selected by the controller; all arithmetic wraps mod 2^32.
    always_comb begin
        npc = pc_q + 32'd4;
        case (npc_sel)
            2'b00:   npc = pc_q + 32'd4;
            2'b01:   npc = pc_link_w + branch_off;
            2'b10:   npc = {pc_link_w[31:28], ir_q[25:0], 2'b00};
            default: npc = rs_data;
        endcase
    end

    // FSM next state plus next values of PC, IR and flags.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        pc_ir_d      = pc_ir_q;
        ir_d         = ir_q;
        ir_valid_d   = ir_valid_q;
        addr_err_d   = addr_err_q;

        case (state_q)
            IDLE, HOLD: begin
                // Capture the pre-update PC even if pc_wr fires in the same cycle.
                if (ir_wr) begin
                    fetch_addr_d = pc_q;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                if (imem.imem_ack) begin
                    ir_d       = imem.imem_rdata;
                    pc_ir_d    = fetch_addr_q;
                    ir_valid_d = 1'b1;
                    state_d    = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase

        // PC updates are frozen while a fetch is outstanding; misaligned targets are refused.
        if (pc_wr && !in_fetch) begin
            if (npc[1:0] != 2'b00) begin
                addr_err_d = 1'b1;
            end else begin
                pc_d = npc;
            end
        end
    end

    // State register with synchronous reset taking priority over all requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            pc_ir_q      <= RESET_PC;
            ir_q         <= 32'd0;
            ir_valid_q   <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            pc_ir_q      <= pc_ir_d;
            ir_q         <= ir_d;
            ir_valid_q   <= ir_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // Memory port: the fetch address is only presented while fetching.
    assign imem.imem_req  = in_fetch;
    assign imem.imem_addr = in_fetch ? fetch_addr_q : pc_q;
    assign stall          = in_fetch && !imem.imem_ack;

    assign ir       = ir_q;
    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign imm16    = ir_q[15:0];
    assign pc       = pc_q;
    assign pc_link  = pc_link_w;
    assign ir_valid = ir_valid_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch latency, stalls, next-PC modes,
// misaligned jumps, wrap-around and reset behaviour during a fetch.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        pc_wr;
    logic        ir_wr;
    logic [1:0]  npc_sel;
    logic [31:0] rs_data;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [31:0] pc;
    logic [31:0] pc_link;
    logic        ir_valid;
    logic        stall;
    logic        addr_err;

    int tests_run;
    int tests_failed;
    int stall_cycles;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_wr    (pc_wr),
        .ir_wr    (ir_wr),
        .npc_sel  (npc_sel),
        .rs_data  (rs_data),
        .imem     (bus.master),
        .ir       (ir),
        .opcode   (opcode),
        .funct    (funct),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .imm16    (imm16),
        .pc       (pc),
        .pc_link  (pc_link),
        .ir_valid (ir_valid),
        .stall    (stall),
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        stall_cycles   = 0;
        reset          = 1'b1;
        pc_wr          = 1'b0;
        ir_wr          = 1'b0;
        npc_sel        = 2'b00;
        rs_data        = 32'd0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_pc",       pc,                 32'h3000);
        check("rst_ir",       ir,                 32'h0);
        check("rst_ir_valid", {31'd0, ir_valid},  32'd0);
        check("rst_req",      {31'd0, bus.imem_req}, 32'd0);
        check("rst_stall",    {31'd0, stall},     32'd0);
        check("rst_addr_err", {31'd0, addr_err},  32'd0);
        check("rst_imem_addr", bus.imem_addr,     32'h3000);
        check("rst_pc_link",  pc_link,            32'h3004);

        // Fetch with ir_wr+pc_wr together, ack in the first fetch cycle
        ir_wr = 1'b1; pc_wr = 1'b1; npc_sel = 2'b00;
        tick();
        ir_wr = 1'b0; pc_wr = 1'b0;
        #1;
        check("f1_req",       {31'd0, bus.imem_req}, 32'd1);
        check("f1_addr",      bus.imem_addr,      32'h3000);
        check("f1_pc",        pc,                 32'h3004);
        check("f1_stall",     {31'd0, stall},     32'd1);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3C01_1234;
        #1;
        check("f1_stall_ack", {31'd0, stall},     32'd0);
        tick();
        bus.imem_ack = 1'b0;
        #1;
        check("f1_ir",        ir,                 32'h3C01_1234);
        check("f1_pc_link",   pc_link,            32'h3004);
        check("f1_opcode",    {26'd0, opcode},    32'h0F);
        check("f1_rt",        {27'd0, rt},        32'h1);
        check("f1_imm16",     {16'd0, imm16},     32'h1234);
        check("f1_ir_valid",  {31'd0, ir_valid},  32'd1);
        check("f1_req_hold",  {31'd0, bus.imem_req}, 32'd0);
        check("f1_addr_hold", bus.imem_addr,      32'h3004);

        // Fetch with ack delayed 3 cycles; pc_wr/ir_wr pulses during FETCH ignored
        ir_wr = 1'b1; pc_wr = 1'b1; npc_sel = 2'b00;
        tick();
        ir_wr = 1'b0; pc_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_wr = (i == 1);
            ir_wr = (i == 1);
            #1;
            if (stall) stall_cycles++;
            tick();
        end
        pc_wr = 1'b0; ir_wr = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2001_0005;
        #1;
        if (stall) stall_cycles++;
        check("f2_addr_kept", bus.imem_addr,      32'h3004);
        tick();
        bus.imem_ack = 1'b0;
        #1;
        check("f2_stall_cnt", stall_cycles,       32'd3);
        check("f2_pc",        pc,                 32'h3008);
        check("f2_ir",        ir,                 32'h2001_0005);
        check("f2_pc_link",   pc_link,            32'h3008);

        // Fetch a beq with imm -1 from 0x3008, then branch
        ir_wr = 1'b1;
        tick();
        ir_wr = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1000_FFFF;
        tick();
        bus.imem_ack = 1'b0;
        #1;
        check("f3_pc_link",   pc_link,            32'h300C);
        check("f3_opcode",    {26'd0, opcode},    32'h04);
        pc_wr = 1'b1; npc_sel = 2'b00;
        tick();
        check("seq_pc",       pc,                 32'h300C);
        npc_sel = 2'b01;
        tick();
        pc_wr = 1'b0;
        check("beq_pc",       pc,                 32'h3008);

        // jr to 0x3000, fetch jal, jump
        rs_data = 32'h3000; npc_sel = 2'b11; pc_wr = 1'b1;
        tick();
        pc_wr = 1'b0;
        check("jr_pc",        pc,                 32'h3000);
        ir_wr = 1'b1;
        tick();
        ir_wr = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0C00_0C10;
        tick();
        bus.imem_ack = 1'b0;
        npc_sel = 2'b10; pc_wr = 1'b1;
        tick();
        pc_wr = 1'b0;
        check("jal_pc",       pc,                 32'h3040);
        check("jal_pc_link",  pc_link,            32'h3004);

        // ack in HOLD must not touch IR
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack = 1'b0;
        check("hold_ack_ir",  ir,                 32'h0C00_0C10);

        // Misaligned jr rejected, sticky error
        rs_data = 32'h3002; npc_sel = 2'b11; pc_wr = 1'b1;
        tick();
        pc_wr = 1'b0;
        check("mis_pc",       pc,                 32'h3040);
        check("mis_err",      {31'd0, addr_err},  32'd1);
        npc_sel = 2'b00; pc_wr = 1'b1;
        tick();
        pc_wr = 1'b0;
        check("mis_pc_next",  pc,                 32'h3044);
        check("mis_err_held", {31'd0, addr_err},  32'd1);

        // Wrap-around at the top of the address space
        rs_data = 32'hFFFF_FFFC; npc_sel = 2'b11; pc_wr = 1'b1;
        tick();
        check("wrap_pre",     pc,                 32'hFFFF_FFFC);
        npc_sel = 2'b00;
        tick();
        pc_wr = 1'b0;
        check("wrap_pc",      pc,                 32'h0);

        // Reset clears the sticky error
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_err",     {31'd0, addr_err},  32'd0);
        check("rst2_pc",      pc,                 32'h3000);

        // Reset during FETCH (with pc_wr/ir_wr asserted), late ack ignored
        ir_wr = 1'b1;
        tick();
        ir_wr = 1'b0;
        check("rf_req",       {31'd0, bus.imem_req}, 32'd1);
        reset = 1'b1; pc_wr = 1'b1; ir_wr = 1'b1; npc_sel = 2'b00;
        tick();
        reset = 1'b0; pc_wr = 1'b0; ir_wr = 1'b0;
        #1;
        check("rf_req_drop",  {31'd0, bus.imem_req}, 32'd0);
        check("rf_pc_prio",   pc,                 32'h3000);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3C01_1234;
        tick();
        bus.imem_ack = 1'b0;
        check("rf_ir",        ir,                 32'h0);
        check("rf_ir_valid",  {31'd0, ir_valid},  32'd0);
        check("rf_pc",        pc,                 32'h3000);
        check("rf_idle_req",  {31'd0, bus.imem_req}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, value loaded into the PC on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pc_wr  input  1  PC write enable from the controller (PC_change_flag).
REQ-005 ir_wr  input  1  fetch start / IR write request from the controller (IRWr).
REQ-006 npc_sel  input  2  next-PC select: 00 = PC+4, 01 = branch, 10 = j/jal, 11 = jr.
REQ-007 rs_data  input  32  register rs value, used as the jr target.
REQ-008 imem_addr  output  32  instruction memory word address.
REQ-009 imem_req  output  1  instruction memory read request.
REQ-010 imem_ack  input  1  instruction memory read complete; imem_rdata is valid in the same cycle.
REQ-011 imem_rdata  input  32  instruction memory read data.
REQ-012 ir  output  32  instruction register.
REQ-013 opcode/funct  output  6/6  ir[31:26] / ir[5:0].
REQ-014 rs/rt/rd  output  5/5/5  ir[25:21] / ir[20:16] / ir[15:11].
REQ-015 imm16  output  16  ir[15:0].
REQ-016 pc  output  32  current PC register.
REQ-017 pc_link  output  32  pc_ir+4, the link value for jal.
REQ-018 ir_valid  output  1  ir holds a fetched instruction.
REQ-019 stall  output  1  fetch is in progress; the controller holds its state while this is high.
REQ-020 addr_err  output  1  sticky flag: a misaligned PC write was rejected.

Function
REQ-021 FSM states are IDLE, FETCH and HOLD; reset enters IDLE.
REQ-022 IDLE/HOLD with ir_wr=1: fetch_addr<=pc and the FSM moves to FETCH on the next edge.
REQ-023 FETCH: imem_req=1, imem_addr=fetch_addr, stall=1 until the ack cycle; stall=0 in the ack cycle.
REQ-024 FETCH with imem_ack=1: ir<=imem_rdata, pc_ir<=fetch_addr, ir_valid<=1, FSM moves to HOLD.
REQ-025 Minimum fetch latency: ir_wr at edge N, ack in cycle N+1, ir valid after edge N+2.
REQ-026 Outside FETCH: imem_req=0 and imem_addr=pc; imem_ack is ignored in IDLE/HOLD.
REQ-027 ir_wr while in FETCH is ignored; fetch_addr is not reloaded.
REQ-028 pc_wr is accepted in IDLE/HOLD only and is ignored in FETCH.
REQ-029 Next PC is computed as follows:
- npc_sel 00: pc+4.
- npc_sel 01: pc_ir+4+({{14{imm16[15]}},imm16,2'b00}).
- npc_sel 10: {pc_link[31:28], ir[25:0], 2'b00}.
- npc_sel 11: rs_data.
REQ-030 All next-PC arithmetic is 32-bit modulo 2^32; wrap at 32'hFFFF_FFFC+4 = 0 is legal.
REQ-031 ir_wr and pc_wr in the same cycle: fetch_addr captures the pre-update pc and pc takes the next-PC value.
REQ-032 An accepted pc_wr whose next PC has [1:0]!=0: pc is unchanged and addr_err<=1, held until reset.
REQ-033 Field outputs (opcode, funct, rs, rt, rd, imm16) are combinational slices of ir.
REQ-034 ir, pc_ir and pc_link hold their values in HOLD until the next ack.

Reset
REQ-035 Reset values: pc=RESET_PC, fetch_addr=RESET_PC, pc_ir=RESET_PC, ir=0, ir_valid=0, addr_err=0, FSM=IDLE; outputs imem_req=0, stall=0.
REQ-036 Reset asserted during FETCH: imem_req drops after that edge and an ack arriving afterwards is ignored (ir stays 0).
REQ-037 Reset has priority over pc_wr and ir_wr in the same cycle.

Verification
REQ-038 Reset, then ir_wr+pc_wr (npc_sel=00), ack with rdata=32'h3C01_1234 in the next cycle -> ir=32'h3C01_1234, pc_ir=32'h3000, pc=32'h3004, pc_link=32'h3004, opcode=6'h0F.
REQ-039 ack delayed 3 cycles -> stall high for exactly 3 cycles; a pc_wr pulse during FETCH leaves pc unchanged.
REQ-040 pc_ir=32'h3008, ir=32'h1000_FFFF (beq, imm -1), pc_wr with npc_sel=01 -> pc=32'h3008.
REQ-041 ir=32'h0C00_0C10 (jal), pc_ir=32'h3000, npc_sel=10 -> pc=32'h0000_3040, pc_link=32'h3004.
REQ-042 npc_sel=11 with rs_data=32'h0000_3002 -> pc unchanged, addr_err=1 and stays set; next reset clears it.
REQ-043 Reset asserted in the cycle after ir_wr, with ack in the following cycle -> ir=0, ir_valid=0, FSM=IDLE, pc=32'h3000.
